// File: rtl/layer_priority_ctrl.sv
// layer_priority_ctrl: per-pixel layer arbitration with a frame-aligned,
// double-buffered priority/blink configuration.
// Optional blink logic is built when LAYER_PRIORITY_CTRL_BLINK_EN is defined;
// otherwise blinkPhase is tied high and cfgBlinkMask is ignored.
module layer_priority_ctrl #(
   parameter int BLINK_FRAMES = 30   // frames per blink half-period, 1..255
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       startOfFrame,
   input  logic [3:0] drawReq,
   input  logic       cfgValid,
   input  logic [7:0] cfgPriority,
   input  logic [3:0] cfgBlinkMask,
   output logic       cfgReady,
   output logic       cfgError,
   output logic       selValid,
   output logic [1:0] selLayer,
   output logic       blinkPhase
);

   localparam logic [7:0] DEF_PRIO = 8'b11_10_01_00;

   typedef enum logic {IDLE, PENDING} state_t;

   state_t     state_q, state_d;
   logic [7:0] shadowPrio_q, activePrio_q;
   logic       cfgError_q;
   logic       selValid_q, selValid_d;
   logic [1:0] selLayer_q, selLayer_d;
   logic [3:0] idSeen;
   logic       prioOk, accept, reject, commit;
   logic [3:0] visible;

   // A priority word is legal only if every layer ID appears once
   always_comb begin
      idSeen = '0;
      for (int s = 0; s < 4; s++) idSeen[cfgPriority[2*s +: 2]] = 1'b1;
      prioOk = &idSeen;
   end

   assign accept = cfgValid && (state_q == IDLE) && prioOk;
   assign reject = cfgValid && (state_q == IDLE) && !prioOk;
   // Commit only from PENDING, so an acceptance on a startOfFrame edge waits
   // for the following frame.
   assign commit = (state_q == PENDING) && startOfFrame;

   // Next-state logic for the configuration handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = PENDING;
         PENDING: if (commit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register, shadow/active priority tables and error pulse
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         shadowPrio_q <= DEF_PRIO;
         activePrio_q <= DEF_PRIO;
         cfgError_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfgError_q <= reject;
         if (accept) shadowPrio_q <= cfgPriority;
         if (commit) activePrio_q <= shadowPrio_q;
      end
   end

`ifdef LAYER_PRIORITY_CTRL_BLINK_EN
   localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

   logic [3:0] shadowMask_q, activeMask_q;
   logic [7:0] frameCnt_q, frameCnt_d;
   logic       blinkPhase_q, blinkPhase_d;

   // Frame counter wraps at the half-period and flips the blink phase
   always_comb begin
      frameCnt_d   = frameCnt_q;
      blinkPhase_d = blinkPhase_q;
      if (startOfFrame) begin
         if (frameCnt_q == LAST_FRAME) begin
            frameCnt_d   = 8'd0;
            blinkPhase_d = !blinkPhase_q;
         end else begin
            frameCnt_d = frameCnt_q + 8'd1;
         end
      end
   end

   // Blink masks follow the same shadow/commit path; counter is free-running
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         shadowMask_q <= '0;
         activeMask_q <= '0;
         frameCnt_q   <= '0;
         blinkPhase_q <= 1'b1;
      end else begin
         frameCnt_q   <= frameCnt_d;
         blinkPhase_q <= blinkPhase_d;
         if (accept) shadowMask_q <= cfgBlinkMask;
         if (commit) activeMask_q <= shadowMask_q;
      end
   end

   assign blinkPhase = blinkPhase_q;
   assign visible    = drawReq & ~(activeMask_q & {4{~blinkPhase_q}});
`else
   logic unusedBlinkMask;
   assign unusedBlinkMask = &{1'b0, cfgBlinkMask};
   assign blinkPhase      = 1'b1;
   assign visible         = drawReq;
`endif

   // Winner is the visible layer in the lowest-numbered slot
   always_comb begin
      selValid_d = |visible;
      selLayer_d = 2'd0;
      for (int s = 3; s >= 0; s--)
         if (visible[activePrio_q[2*s +: 2]]) selLayer_d = activePrio_q[2*s +: 2];
   end

   // One-cycle registered selection to line up with the colour mux
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         selValid_q <= 1'b0;
         selLayer_q <= 2'd0;
      end else begin
         selValid_q <= selValid_d;
         selLayer_q <= selLayer_d;
      end
   end

   assign cfgReady = (state_q == IDLE);
   assign cfgError = cfgError_q;
   assign selValid = selValid_q;
   assign selLayer = selLayer_q;

endmodule

// File: tb/tb_layer_priority_ctrl.sv
// Directed self-checking bench for layer_priority_ctrl (BLINK_FRAMES=2).
module tb_layer_priority_ctrl;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       startOfFrame = 1'b0;
   logic [3:0] drawReq = '0;
   logic       cfgValid = 1'b0;
   logic [7:0] cfgPriority = '0;
   logic [3:0] cfgBlinkMask = '0;
   logic       cfgReady, cfgError, selValid, blinkPhase;
   logic [1:0] selLayer;

   int checks = 0;
   int errors = 0;

   layer_priority_ctrl #(.BLINK_FRAMES(2)) dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .drawReq(drawReq),
      .cfgValid(cfgValid), .cfgPriority(cfgPriority), .cfgBlinkMask(cfgBlinkMask),
      .cfgReady(cfgReady), .cfgError(cfgError), .selValid(selValid),
      .selLayer(selLayer), .blinkPhase(blinkPhase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetN = 1'b0;
      startOfFrame = 1'b0; cfgValid = 1'b0; drawReq = '0;
      tick(); tick();
      resetN = 1'b1;
   endtask

   task automatic offer(input logic [7:0] prio, input logic [3:0] mask, input logic sof);
      cfgValid = 1'b1; cfgPriority = prio; cfgBlinkMask = mask; startOfFrame = sof;
      tick();
      cfgValid = 1'b0; startOfFrame = 1'b0;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   initial begin
      // reset values
      tick();
      check("rst_ready", {7'd0, cfgReady}, 8'd1);
      check("rst_error", {7'd0, cfgError}, 8'd0);
      check("rst_selValid", {7'd0, selValid}, 8'd0);
      check("rst_selLayer", {6'd0, selLayer}, 8'd0);
      check("rst_phase", {7'd0, blinkPhase}, 8'd1);
      do_reset();

      // default priority: layer 1 beats layer 3
      drawReq = 4'b1010; tick();
      check("def_valid", {7'd0, selValid}, 8'd1);
      check("def_layer", {6'd0, selLayer}, 8'd1);

      // background
      drawReq = 4'b0000; tick();
      check("bg_valid", {7'd0, selValid}, 8'd0);
      check("bg_layer", {6'd0, selLayer}, 8'd0);

      // accept reversed priority mid-frame; no change until startOfFrame
      drawReq = 4'b1010;
      offer(8'b00_01_10_11, 4'b0000, 1'b0);
      check("pend_ready", {7'd0, cfgReady}, 8'd0);
      check("pend_layer0", {6'd0, selLayer}, 8'd1);
      tick(); tick();
      check("pend_layer1", {6'd0, selLayer}, 8'd1);
      check("pend_ready1", {7'd0, cfgReady}, 8'd0);
      frame();
      check("commit_edge_layer", {6'd0, selLayer}, 8'd1);
      tick();
      check("commit_layer", {6'd0, selLayer}, 8'd3);
      check("commit_ready", {7'd0, cfgReady}, 8'd1);

      // duplicate ID rejected: one-cycle error, table unchanged
      drawReq = 4'b0011;
      offer(8'b00_00_10_11, 4'b0000, 1'b0);
      check("rej_error", {7'd0, cfgError}, 8'd1);
      check("rej_ready", {7'd0, cfgReady}, 8'd1);
      tick();
      check("rej_error_clr", {7'd0, cfgError}, 8'd0);
      frame(); tick();
      check("rej_table", {6'd0, selLayer}, 8'd1);

      // acceptance on a startOfFrame edge commits at the following frame
      drawReq = 4'b1010;
      offer(8'b11_10_01_00, 4'b0000, 1'b1);
      check("same_ready", {7'd0, cfgReady}, 8'd0);
      tick();
      check("same_nocommit", {6'd0, selLayer}, 8'd3);
      frame(); tick();
      check("same_commit", {6'd0, selLayer}, 8'd1);
      check("same_ready1", {7'd0, cfgReady}, 8'd1);

      // reset while PENDING discards the shadow
      offer(8'b00_01_10_11, 4'b0000, 1'b0);
      check("mid_pending", {7'd0, cfgReady}, 8'd0);
      resetN = 1'b0; #3;
      check("mid_rst_ready", {7'd0, cfgReady}, 8'd1);
      tick();
      resetN = 1'b1;
      drawReq = 4'b1010;
      frame(); tick();
      check("mid_layer", {6'd0, selLayer}, 8'd1);
      check("mid_ready", {7'd0, cfgReady}, 8'd1);

      // blink: mask layer 0, counter/phase start fresh after reset
      do_reset();
      drawReq = 4'b0011;
      offer(8'b11_10_01_00, 4'b0001, 1'b0);
      begin
         logic [1:0] expL [5];
         logic       expP [5];
`ifdef LAYER_PRIORITY_CTRL_BLINK_EN
         expL = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
         expP = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
         expL = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
         expP = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
         for (int f = 0; f < 5; f++) begin
            frame(); tick();
            check($sformatf("blink_layer%0d", f), {6'd0, selLayer}, {6'd0, expL[f]});
            check($sformatf("blink_phase%0d", f), {7'd0, blinkPhase}, {7'd0, expP[f]});
            check($sformatf("blink_valid%0d", f), {7'd0, selValid}, 8'd1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/layer_priority_ctrl.md
LAYER_PRIORITY_CTRL -- requirements
Module: layer_priority_ctrl

Interface
REQ-001 The block SHALL have parameter BLINK_FRAMES, default 30, meaning the number of frames per blink half-period, with a legal range of 1..255.
REQ-002 The block SHALL have the following ports, with the clock and reset first:
- clk, input, 1 bit: system clock; resetN is asynchronous, active-low.
- resetN, input, 1 bit: asynchronous active-low reset.
- startOfFrame, input, 1 bit: single-cycle pulse at the first pixel of each frame.
- drawReq, input, 4 bits: per-layer drawing request for the current pixel; bit n is layer n.
- cfgValid, input, 1 bit: a configuration word is offered.
- cfgPriority, input, 8 bits: four 2-bit layer IDs; [1:0] is slot0 (highest) and [7:6] is slot3 (lowest).
- cfgBlinkMask, input, 4 bits: per-layer blink enable.
- cfgReady, output, 1 bit: the block can accept a configuration.
- cfgError, output, 1 bit: one-cycle pulse when an offered configuration is rejected.
- selValid, output, 1 bit: a layer wins the current pixel; 0 selects the background.
- selLayer, output, 2 bits: index of the winning layer.
- blinkPhase, output, 1 bit: current blink phase; 1 means blinking layers are visible.

Function
REQ-003 A configuration SHALL be accepted on a rising clk edge where cfgValid and cfgReady are both 1 and cfgPriority is a permutation of {0,1,2,3}.
- The accepted cfgPriority and cfgBlinkMask are captured into shadow registers.
- cfgReady is deasserted on the next cycle.
REQ-004 If cfgValid and cfgReady are 1 and cfgPriority contains a duplicate ID, the block SHALL:
- pulse cfgError for exactly one cycle on the following cycle;
- leave the shadow and active registers unchanged;
- keep cfgReady at 1.
REQ-005 Shadow-to-active commit SHALL occur on the first startOfFrame strictly after acceptance, after which cfgReady returns to 1 on the next cycle.
- A pending configuration never changes the active table mid-frame.
REQ-006 If acceptance and startOfFrame occur on the same edge, the commit SHALL occur at the following startOfFrame, not the current one.
REQ-007 The controller SHALL implement the states IDLE (cfgReady=1) and PENDING (cfgReady=0) with these transitions only:
- IDLE to PENDING on a valid acceptance;
- PENDING to IDLE on the commit edge.
REQ-008 The controller SHALL compute visible[n] as drawReq[n] AND NOT (activeBlinkMask[n] AND NOT blinkPhase).
REQ-009 selLayer SHALL be the layer ID in the lowest-numbered active slot whose visible bit is 1, and selValid SHALL be 1 when any visible bit is 1.
- When no visible bit is 1, selValid is 0 and selLayer is 0.
REQ-010 selValid and selLayer SHALL be registered with exactly one clk cycle of latency from drawReq, matching the registered colour mux downstream.
REQ-011 The blink frame counter SHALL be 8 bits and increment on each startOfFrame.
- At BLINK_FRAMES-1 it wraps to 0 and blinkPhase toggles on the same edge.
REQ-012 A new blink mask committed per REQ-005 SHALL take effect from the commit edge, and the frame counter and blinkPhase SHALL NOT be reset by a commit.
REQ-013 cfgError and a commit SHALL be able to occur in the same cycle without interacting.

Reset
REQ-014 While resetN=0, the block SHALL hold the following values:
- active and shadow priority = 8'b11_10_01_00 (layer 0 highest);
- active and shadow blink mask = 4'b0000;
- state = IDLE, cfgReady = 1, cfgError = 0;
- selValid = 0, selLayer = 0;
- frame counter = 0, blinkPhase = 1.
REQ-015 Reset asserted in PENDING SHALL discard the shadow configuration, and no commit SHALL follow reset release.

Configuration
REQ-016 With macro LAYER_PRIORITY_CTRL_BLINK_EN defined, the blink counter, blinkPhase and blink masking SHALL operate per REQ-008, REQ-011 and REQ-012.
REQ-017 Without LAYER_PRIORITY_CTRL_BLINK_EN, the blink logic SHALL be removed, with these results:
- blinkPhase is tied to 1;
- cfgBlinkMask is ignored;
- visible equals drawReq.
- All other behaviour is unchanged.

Verification
REQ-018 Reset priority: after reset, drive drawReq=4'b1010 -> one cycle later selValid=1 and selLayer=1.
REQ-019 Frame-aligned commit: in IDLE, offer cfgPriority=8'b00_01_10_11 with no startOfFrame, then drive drawReq=4'b1010 -> cfgReady=0 and selLayer stays 1 until the next startOfFrame; on the cycle after that commit, drawReq=4'b1010 gives selLayer=3 and cfgReady=1.
REQ-020 Rejected configuration: offer cfgPriority=8'b00_00_10_11 -> cfgError is high for exactly one cycle, cfgReady stays 1, and the active table is unchanged.
REQ-021 Same-edge acceptance: accept a configuration on the same edge as startOfFrame -> no commit at that frame; commit occurs at the next startOfFrame.
REQ-022 Blink (BLINK_EN defined, BLINK_FRAMES=2): commit blink mask 4'b0001, then hold drawReq=4'b0011 -> selLayer alternates 0,0 / 1,1 over successive frame pairs, and blinkPhase toggles every 2 startOfFrame pulses.
REQ-023 Background and mid-operation reset: drive drawReq=0 -> selValid=0 and selLayer=0; assert resetN=0 while PENDING -> after release cfgReady=1 and the default priority stays active across the next startOfFrame.
